// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared constants and types for the AES-128 pipeline and its
//               output buffering logic.
//               AES_BLOCK_W     - cipher block width in bits
//               AES128_PIPE_LAT - issue-to-output latency of the aes_128 core
//               aes_block_t     - one 128-bit cipher block
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int AES_BLOCK_W     = 128;
    localparam int AES128_PIPE_LAT = 11;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_fwft
// Description : Synchronous first-word-fall-through FIFO. The head entry is
//               presented combinationally on o_pop_data whenever the FIFO is
//               not empty, and reads as zero when it is empty. A write becomes
//               visible the cycle after it is pushed (no bypass when empty).
//               A push while full is stored only if a pop happens in the same
//               cycle; otherwise it is ignored.
// Ports       : clk, rst_n      - clock, synchronous active-low reset
//               i_push/i_push_data - write strobe and data
//               i_pop           - consume head entry (ignored when empty)
//               o_pop_data      - head entry, '0 when empty
//               o_level         - occupancy, 0..DEPTH
//               o_full/o_empty  - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft
#(
    parameter int W     = 128,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [W-1:0]             i_push_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_pop_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_lvl_w = c_ptr_w + 1;

    logic [W-1:0]       r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_lvl_w-1:0] r_level;

    logic w_do_push;
    logic w_do_pop;

    assign o_empty  = (r_level == '0);
    assign o_full   = (r_level == c_lvl_w'(DEPTH));
    assign w_do_pop = i_pop & ~o_empty;
    // When full, the slot being popped this cycle is the one written, so a
    // simultaneous push/pop keeps the FIFO full without losing data.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    assign o_level    = r_level;
    assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= r_level + c_lvl_w'(w_do_push) - c_lvl_w'(w_do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_128_out_buffer.sv
`default_nettype none
// ============================================================================
// Module      : aes_128_out_buffer
// Description : Output companion for the free-running aes_128 pipeline. Tags
//               every accepted issue, follows the tag down a shift register
//               matching the core latency, captures the matching ciphertext
//               into a FWFT FIFO and presents it on a ready/valid port.
//               Credits (issue_ok) count stored plus in-flight blocks so the
//               FIFO can never overflow when the issuer honours them.
// Ports       : clk, rst_n  - clock, synchronous active-low reset
//               issue       - upstream places a real block on the core input
//               issue_ok    - credit available (registered-state only)
//               core_out    - aes_128 ciphertext output
//               core_valid  - aes_128 pipeline-filled indicator
//               m_data      - FIFO head ciphertext, '0 when m_valid=0
//               m_valid     - FIFO not empty
//               m_ready     - consumer accepts m_data
//               level       - FIFO occupancy
//               err         - sticky protocol error flag
// Revision    : 1.0 - initial release
// ============================================================================
module aes_128_out_buffer
    import aes_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int LATENCY = AES128_PIPE_LAT,
    parameter int W       = AES_BLOCK_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       issue,
    output logic                       issue_ok,
    input  logic [W-1:0]               core_out,
    input  logic                       core_valid,
    output logic [W-1:0]               m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       err
);

    localparam int c_inf_w = $clog2(LATENCY + 1);

    logic [LATENCY-1:0] r_tag_sr;
    logic [c_inf_w-1:0] r_inflight;
    logic               r_err;

    logic               w_acc;
    logic               w_tag_out;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_err_evt;
    logic [31:0]        w_credit_sum;

    // Credits cover both stored blocks and blocks still inside the core, so
    // every tagged ciphertext is guaranteed a FIFO slot on arrival.
    assign w_credit_sum = 32'(level) + 32'(r_inflight);
    assign issue_ok     = (w_credit_sum < 32'(DEPTH));

    assign w_acc     = issue & issue_ok;
    assign w_tag_out = r_tag_sr[LATENCY-1];
    assign w_push    = w_tag_out & core_valid;
    assign m_valid   = ~w_empty;
    assign w_pop     = m_valid & m_ready;

    assign w_err_evt = (issue & ~issue_ok)
                     | (w_tag_out & ~core_valid)
                     | (w_push & ~w_pop & w_full);

    assign err = r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tag_sr   <= '0;
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            r_tag_sr   <= {r_tag_sr[LATENCY-2:0], w_acc};
            // A tag leaving the shift register always hands its credit over
            // to the FIFO level (or is lost with err set).
            r_inflight <= r_inflight + c_inf_w'(w_acc) - c_inf_w'(w_tag_out);
            if (w_err_evt) begin
                r_err <= 1'b1;
            end
        end
    end

    sync_fifo_fwft #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (core_out),
        .i_pop       (w_pop),
        .o_pop_data  (m_data),
        .o_level     (level),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_aes_128_out_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_128_out_buffer
// Description : Self-checking bench for aes_128_out_buffer. Contains a
//               behavioural AES-128 core stand-in (11-cycle latency, fixed
//               key 000102..0f) and a queue-based reference model of the
//               buffer built from accept times and occupancy rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_128_out_buffer;
    import aes_pkg::*;

    localparam int LAT   = 11;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             issue = 1'b0;
    logic             issue_ok;
    aes_block_t       in_bus = '0;
    aes_block_t       core_out;
    logic             core_valid;
    aes_block_t       m_data;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [4:0]       level;
    logic             err;

    always #5 clk = ~clk;

    aes_128_out_buffer #(
        .DEPTH   (DEPTH),
        .LATENCY (LAT),
        .W       (128)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue      (issue),
        .issue_ok   (issue_ok),
        .core_out   (core_out),
        .core_valid (core_valid),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .level      (level),
        .err        (err)
    );

    // ---------------- behavioural AES-128 ----------------
    logic [7:0]   sbox_t [256];
    logic [127:0] rk [11];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic init_aes();
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rcon;
        logic [127:0] key;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] x;
            logic [7:0] inv;
            x   = i[7:0];
            inv = 8'h00;
            if (x != 8'h00) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, x);
            end
            sbox_t[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                      ^ rotl8(inv, 4) ^ 8'h63;
        end
        key  = 128'h000102030405060708090a0b0c0d0e0f;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]}
                  ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] st;
        st = pt ^ rk[0];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[st[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) t[4*c+q] = s[4*((c+q)%4)+q];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) st[127-8*i -: 8] = t[i];
            st = st ^ rk[r];
        end
        return st;
    endfunction

    // Core stand-in: samples in_bus every cycle, result LAT cycles later.
    aes_block_t core_pipe [LAT];
    int         fill_cnt;
    always_ff @(posedge clk) begin
        core_pipe[0] <= aes_enc(in_bus);
        for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
        if (!rst_n)             fill_cnt <= 0;
        else if (fill_cnt < LAT) fill_cnt <= fill_cnt + 1;
    end
    assign core_out   = core_pipe[LAT-1];
    assign core_valid = (fill_cnt >= LAT);

    // ---------------- reference model ----------------
    typedef struct {
        aes_block_t data;
        int         acc_cyc;
    } ent_t;

    ent_t q[$];
    int   cyc     = 0;
    bit   exp_err = 1'b0;
    int   popped  = 0;
    int   checks  = 0;
    int   errors  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // A block is visible in the FIFO one cycle after its ciphertext arrives.
    function automatic int exp_level();
        int n = 0;
        foreach (q[i]) if (q[i].acc_cyc + LAT + 1 <= cyc) n++;
        return n;
    endfunction

    task automatic check_all();
        int lvl;
        lvl = exp_level();
        chk("level",    128'(level),    128'(lvl));
        chk("m_valid",  128'(m_valid),  128'(lvl > 0));
        if (lvl > 0) chk("m_data", m_data, q[0].data);
        else         chk("m_data_idle", m_data, 128'h0);
        chk("issue_ok", 128'(issue_ok), 128'(q.size() < DEPTH));
        chk("err",      128'(err),      128'(exp_err));
    endtask

    task automatic tick();
        bit ok;
        ok = (q.size() < DEPTH);
        if (!rst_n) begin
            q.delete();
            exp_err = 1'b0;
        end else begin
            if (m_ready && exp_level() > 0) begin
                void'(q.pop_front());
                popped++;
            end
            if (issue) begin
                if (ok) q.push_back('{aes_enc(in_bus), cyc});
                else    exp_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    function automatic aes_block_t rnd_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int iss_cyc, first, nvalid, p0, accepted;
        bit ok_dropped;
        aes_block_t fips_pt, fips_ct;
        fips_pt = 128'h00112233445566778899aabbccddeeff;
        fips_ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        init_aes();

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        cyc   = 0;

        // 1. single known-answer block, latency and one-cycle visibility
        m_ready = 1'b1;
        while (cyc < 5) tick();
        issue   = 1'b1;
        in_bus  = fips_pt;
        iss_cyc = cyc;
        tick();
        issue  = 1'b0;
        in_bus = rnd_blk();
        first  = -1;
        nvalid = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_valid) begin
                nvalid++;
                if (first < 0) begin
                    first = cyc;
                    chk("t1_ciphertext", m_data, fips_ct);
                end
            end
        end
        chk("t1_first_valid_cycle", 128'(first), 128'(iss_cyc + LAT + 1));
        chk("t1_valid_cycles", 128'(nvalid), 128'(1));

        // 2. back-to-back issue, full throughput
        p0 = popped;
        ok_dropped = 1'b0;
        for (int i = 0; i < 40; i++) begin
            issue  = 1'b1;
            in_bus = rnd_blk();
            if (!issue_ok) ok_dropped = 1'b1;
            tick();
        end
        issue = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("t2_outputs", 128'(popped - p0), 128'(40));
        chk("t2_issue_ok_held", 128'(ok_dropped), 128'(0));

        // 3. stalled consumer, credit exhaustion, then drain
        m_ready  = 1'b0;
        accepted = 0;
        for (int i = 0; i < 30; i++) begin
            issue  = issue_ok;
            in_bus = rnd_blk();
            if (issue_ok) accepted++;
            tick();
        end
        issue = 1'b0;
        chk("t3_accepted", 128'(accepted), 128'(DEPTH));
        chk("t3_level_full", 128'(level), 128'(DEPTH));
        chk("t3_credit_out", 128'(issue_ok), 128'(0));
        p0 = popped;
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("t3_drained", 128'(popped - p0), 128'(DEPTH));

        // 4. random issue / ready with credits honoured
        for (int i = 0; i < 300; i++) begin
            issue   = issue_ok && ($urandom_range(3) != 0);
            in_bus  = rnd_blk();
            m_ready = ($urandom_range(2) != 0);
            tick();
        end
        issue   = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        chk("t4_empty", 128'(q.size()), 128'(0));
        chk("t4_err_clear", 128'(err), 128'(0));

        // 5. issue forced without credit
        m_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            issue  = issue_ok;
            in_bus = rnd_blk();
            tick();
        end
        issue  = 1'b1;
        in_bus = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
        tick();
        issue = 1'b0;
        chk("t5_err_set", 128'(err), 128'(1));
        for (int i = 0; i < 3; i++) tick();
        chk("t5_err_sticky", 128'(err), 128'(1));
        m_ready = 1'b1;
        for (int i = 0; i < 25; i++) tick();
        chk("t5_drained", 128'(q.size()), 128'(0));

        // 6. reset mid-stream
        for (int i = 0; i < 20; i++) begin
            issue   = issue_ok;
            in_bus  = rnd_blk();
            m_ready = ($urandom_range(1) != 0);
            tick();
        end
        issue = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_m_valid", 128'(m_valid), 128'(0));
        chk("t6_level", 128'(level), 128'(0));
        chk("t6_issue_ok", 128'(issue_ok), 128'(1));
        chk("t6_err", 128'(err), 128'(0));
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            issue  = issue_ok;
            in_bus = rnd_blk();
            tick();
        end
        issue = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("t6_empty", 128'(q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
